// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// program_loader_pkg : shared loader state, byte-enable constant, lane order
// Revision: 1.0
// ============================================================================
package program_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } loader_state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;

  // Big-endian lane: byte 0 of a word sits in lane 3 ([31:24]).
  function automatic logic [1:0] lane_of(input logic [1:0] idx);
    return 2'd3 - idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
// byte_word_packer : inserts a byte into its big-endian lane, flags filled lanes
// Revision: 1.0
// ============================================================================
module byte_word_packer
  import program_loader_pkg::*;
(
  input  logic [31:0] i_pack,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [3:0]  o_byte_en
);

  logic [1:0] w_lane;

  always_comb begin
    w_lane                        = lane_of(i_idx);
    o_word                        = i_pack;
    o_word[{w_lane, 3'b000} +: 8] = i_byte;
    // Lanes from 3 down to the current one are filled.
    o_byte_en                     = BE_FULL << w_lane;
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// program_loader : byte-stream to big-endian word writer for program memory
// Revision: 1.0
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_BYTES = 100,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Length,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Mem_write_en,
  output logic [ADDR_W-1:0] Mem_write_addr,
  output logic [31:0]       Mem_write_data,
  output logic [3:0]        Mem_byte_en,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        Checksum
);

  localparam logic [ADDR_W-1:0] C_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_MEM_BYTES = ADDR_W'(MEM_BYTES);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_len;
  logic [31:0]       r_pack;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [3:0]        r_be;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_csum;

  logic              w_xfer;
  logic [ADDR_W-1:0] w_cnt_next;
  logic              w_flush;
  logic [31:0]       w_word;
  logic [3:0]        w_be;

  assign w_xfer     = r_ready & Byte_valid;
  assign w_cnt_next = r_count + C_ONE;
  assign w_flush    = (r_count[1:0] == 2'd3) || (w_cnt_next == r_len);

  byte_word_packer u_packer (
    .i_pack    (r_pack),
    .i_idx     (r_count[1:0]),
    .i_byte    (Byte_in),
    .o_word    (w_word),
    .o_byte_en (w_be)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_pack  <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_csum  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Start) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_csum  <= '0;
            r_count <= '0;
            r_pack  <= '0;
            r_len   <= Length;
            if (Length == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (Length > C_MEM_BYTES) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_count <= w_cnt_next;
            r_csum  <= r_csum + Byte_in;
            r_ready <= (w_cnt_next < r_len);
            if (w_flush) begin
              r_we   <= 1'b1;
              r_addr <= {r_count[ADDR_W-1:2], 2'b00};
              r_data <= w_word;
              r_be   <= w_be;
              r_pack <= '0;
            end else begin
              r_pack <= w_word;
            end
          end else if (r_count == r_len) begin
            // Final write is on the bus this cycle; finish on the next.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Byte_ready     = r_ready;
  assign Mem_write_en   = r_we;
  assign Mem_write_addr = r_addr;
  assign Mem_write_data = r_data;
  assign Mem_byte_en    = r_be;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign Error          = r_err;
  assign Checksum       = r_csum;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// tb_program_loader : table-driven loads with a write scoreboard, plus corners
// Revision: 1.0
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] Length;
  logic [7:0]  Byte_in;
  logic        Byte_valid;
  logic        Byte_ready;
  logic        Mem_write_en;
  logic [31:0] Mem_write_addr;
  logic [31:0] Mem_write_data;
  logic [3:0]  Mem_byte_en;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [7:0]  Checksum;

  program_loader #(.MEM_BYTES(100), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .Length         (Length),
    .Byte_in        (Byte_in),
    .Byte_valid     (Byte_valid),
    .Byte_ready     (Byte_ready),
    .Mem_write_en   (Mem_write_en),
    .Mem_write_addr (Mem_write_addr),
    .Mem_write_data (Mem_write_data),
    .Mem_byte_en    (Mem_byte_en),
    .Busy           (Busy),
    .Done           (Done),
    .Error          (Error),
    .Checksum       (Checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    int          len;
    int          base;
    int          step;
    int          gap;
    logic [7:0]  csum;
    logic [31:0] last_data;
    logic [3:0]  last_be;
  } vec_t;

  wr_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mon_data;
  logic [3:0]  mon_be;
  logic [31:0] m_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (Mem_write_en) begin
      wr_t e;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h be %0h", Mem_write_addr, Mem_write_data, Mem_byte_en);
      end else begin
        e = sb.pop_front();
        if (Mem_write_addr !== e.addr || Mem_write_data !== e.data || Mem_byte_en !== e.be) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h be %0h expected addr %0h data %0h be %0h",
                   Mem_write_addr, Mem_write_data, Mem_byte_en, e.addr, e.data, e.be);
        end
      end
      mon_data = Mem_write_data;
      mon_be   = Mem_byte_en;
    end
  end

  task automatic start_pulse(input int len);
    @(posedge clk); #1;
    Start  = 1'b1;
    Length = len;
    @(posedge clk); #1;
    Start  = 1'b0;
    Length = $urandom;
  endtask

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int n, input int len);
    int t;
    Byte_in    = b;
    Byte_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!Byte_ready && t < 50);
    if (!Byte_ready) check("ready_timeout", 0, 1);
    m_word[8*(3 - (n % 4)) +: 8] = b;
    if ((n % 4) == 3 || n == len - 1) begin
      wr_t e;
      e.addr = n - (n % 4);
      e.data = m_word;
      case (n % 4)
        0:       e.be = 4'b1000;
        1:       e.be = 4'b1100;
        2:       e.be = 4'b1110;
        default: e.be = 4'b1111;
      endcase
      sb.push_back(e);
      m_word = '0;
    end
    @(posedge clk); #1;
    Byte_valid = 1'b0;
    Byte_in    = $urandom;
  endtask

  task automatic run_load(input vec_t v, input int glitch_at, input string tag);
    m_word = '0;
    start_pulse(v.len);
    @(negedge clk);
    check({tag, "_start_flags"}, {Busy, Done, Error, Byte_ready, Checksum}, {4'b1001, 8'h00});
    @(posedge clk); #1;
    for (int n = 0; n < v.len; n++) begin
      if (n == glitch_at) begin
        Start  = 1'b1;
        Length = 2;
        @(posedge clk); #1;
        Start  = 1'b0;
      end
      if (n > 0) repeat (v.gap) begin
        @(posedge clk); #1;
      end
      send_byte(8'(v.base + n * v.step), n, v.len);
    end
    @(negedge clk);
    check({tag, "_final_write_cycle"}, {Mem_write_en, Busy, Done, Byte_ready}, 4'b1100);
    @(negedge clk);
    check({tag, "_done"}, {Mem_write_en, Busy, Done, Error, Byte_ready}, 5'b00100);
    check({tag, "_checksum"}, Checksum, v.csum);
    check({tag, "_last_word"}, {mon_data, mon_be}, {v.last_data, v.last_be});
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    logic acc;

    vecs[0] = '{len: 8,   base: 'h00, step: 1, gap: 0, csum: 8'h1C, last_data: 32'h04050607, last_be: 4'hF};
    vecs[1] = '{len: 6,   base: 'h10, step: 1, gap: 1, csum: 8'h6F, last_data: 32'h14150000, last_be: 4'hC};
    vecs[2] = '{len: 7,   base: 'h20, step: 1, gap: 0, csum: 8'hF5, last_data: 32'h24252600, last_be: 4'hE};
    vecs[3] = '{len: 5,   base: 'hF0, step: 1, gap: 2, csum: 8'hBA, last_data: 32'hF4000000, last_be: 4'h8};
    vecs[4] = '{len: 1,   base: 'h80, step: 1, gap: 0, csum: 8'h80, last_data: 32'h80000000, last_be: 4'h8};
    vecs[5] = '{len: 100, base: 'h00, step: 1, gap: 0, csum: 8'h56, last_data: 32'h60616263, last_be: 4'hF};

    reset = 1'b1; Start = 1'b0; Length = '0; Byte_in = '0; Byte_valid = 1'b0;
    mon_data = '0; mon_be = '0; m_word = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs",
          {Byte_ready, Mem_write_en, Mem_write_addr, Mem_write_data, Mem_byte_en, Busy, Done, Error, Checksum},
          '0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_load(vecs[i], -1, $sformatf("vec%0d", i));

    // Zero length: straight to Done, no handshake, no writes.
    start_pulse(0);
    @(negedge clk);
    check("len0_flags", {Done, Error, Busy, Byte_ready}, 4'b1000);
    Byte_valid = 1'b1;
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | Byte_ready | Mem_write_en;
    end
    Byte_valid = 1'b0;
    check("len0_quiet", acc, 1'b0);

    // Over-length: Error, never ready, then a normal load clears it.
    start_pulse(101);
    @(negedge clk);
    check("len101_flags", {Done, Error, Busy, Byte_ready}, 4'b0100);
    Byte_valid = 1'b1;
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | Byte_ready | Mem_write_en;
    end
    Byte_valid = 1'b0;
    check("len101_quiet", {acc, Error, Checksum}, {2'b01, 8'h00});
    v = '{len: 4, base: 'h01, step: 1, gap: 0, csum: 8'h0A, last_data: 32'h01020304, last_be: 4'hF};
    run_load(v, -1, "after_err");

    // Reset after 5 of 8 bytes: partial second word must be dropped.
    m_word = '0;
    start_pulse(8);
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) send_byte(8'(n), n, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midload_reset_outputs",
          {Byte_ready, Mem_write_en, Mem_write_addr, Mem_write_data, Mem_byte_en, Busy, Done, Error, Checksum},
          '0);
    check("midload_reset_sb", sb.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    v = '{len: 4, base: 'hAA, step: 'h11, gap: 0, csum: 8'h0E, last_data: 32'hAABBCCDD, last_be: 4'hF};
    run_load(v, -1, "after_reset");

    // Start during LOAD must not disturb the running 8-byte load.
    v = '{len: 8, base: 'h40, step: 1, gap: 0, csum: 8'h1C + 8'h00, last_data: 32'h44454647, last_be: 4'hF};
    v.csum = 8'(8 * 'h40 + 28);
    run_load(v, 3, "start_in_load");

    repeat (5) @(posedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
